// File: rtl/fp_mul_seq.sv
// fp_mul_seq: multi-cycle multiplier for the unsigned FP format
// {exp, explicit man}. The mantissas are multiplied by radix-2 shift-add,
// the product is post-normalised one bit per cycle, and overflow and
// underflow saturate. Valid/ready handshakes are on both sides.
//
// state | meaning
// IDLE  | waiting for an operand pair; in_ready high
// MUL   | MAN_W shift-add iterations into the accumulator
// NORM  | left-shift the truncated product until its MSB is set, then resolve flags
// DONE  | result held; waiting for out_ready
module fp_mul_seq #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 11,
    parameter int BIAS  = 2**(EXP_W-1)-1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W-1:0] in_a,
    input  logic [EXP_W+MAN_W-1:0] in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W-1:0] out_result,
    output logic                   out_ovf,
    output logic                   out_unf,
    output logic                   busy
);

    localparam int W   = EXP_W + MAN_W;
    localparam int CW  = $clog2(MAN_W + 1);
    localparam int ESW = EXP_W + 2;
    // The working exponent carries extra headroom so that it cannot wrap
    // during up to MAN_W-1 normalisation decrements.
    localparam int EW  = ESW + CW;
    localparam logic signed [EW-1:0] E_MAX = EW'(2**EXP_W - 1);

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t                  state_q;
    logic [2*MAN_W-1:0]      mcand_q;
    logic [2*MAN_W-1:0]      acc_q;
    logic [2*MAN_W-1:0]      acc_d;
    logic [MAN_W-1:0]        man_b_q;
    logic [MAN_W-1:0]        pm_q;
    logic [CW-1:0]           cnt_q;
    logic signed [ESW-1:0]   esum_q;
    logic signed [ESW-1:0]   esum_d;
    logic signed [EW-1:0]    e_q;
    logic [W-1:0]            res_q;
    logic                    ovf_q;
    logic                    unf_q;

    // One shift-add step: add the shifted multiplicand when the multiplier LSB is set.
    always_comb begin
        acc_d = acc_q;
        if (man_b_q[0]) acc_d = acc_q + mcand_q;
    end

    // Biased exponent sum of the incoming operands.
    always_comb begin
        esum_d = ESW'({2'b00, in_a[W-1:MAN_W]}) + ESW'({2'b00, in_b[W-1:MAN_W]}) - ESW'(BIAS);
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            man_b_q <= '0;
            pm_q    <= '0;
            cnt_q   <= '0;
            esum_q  <= '0;
            e_q     <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mcand_q <= {{MAN_W{1'b0}}, in_a[MAN_W-1:0]};
                        man_b_q <= in_b[MAN_W-1:0];
                        esum_q  <= esum_d;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= MUL;
                    end
                end
                MUL: begin
                    acc_q   <= acc_d;
                    mcand_q <= mcand_q << 1;
                    man_b_q <= man_b_q >> 1;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == CW'(MAN_W - 1)) begin
                        // Truncate to the upper half; no rounding.
                        pm_q    <= acc_d[2*MAN_W-1:MAN_W];
                        e_q     <= EW'(esum_q);
                        state_q <= NORM;
                    end
                end
                NORM: begin
                    if (pm_q == '0) begin
                        res_q   <= '0;
                        ovf_q   <= 1'b0;
                        unf_q   <= 1'b0;
                        state_q <= DONE;
                    end else if (pm_q[MAN_W-1]) begin
                        if (e_q > E_MAX) begin
                            res_q <= '1;
                            ovf_q <= 1'b1;
                            unf_q <= 1'b0;
                        end else if (e_q[EW-1]) begin
                            res_q <= '0;
                            ovf_q <= 1'b0;
                            unf_q <= 1'b1;
                        end else begin
                            res_q <= {e_q[EXP_W-1:0], pm_q};
                            ovf_q <= 1'b0;
                            unf_q <= 1'b0;
                        end
                        state_q <= DONE;
                    end else begin
                        pm_q <= pm_q << 1;
                        e_q  <= e_q - EW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign out_result = res_q;
    assign out_ovf    = ovf_q;
    assign out_unf    = unf_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed bench for fp_mul_seq at default parameters (EXP_W=5, MAN_W=11).
module tb_fp_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        out_ovf;
    logic        out_unf;
    logic        busy;

    int checks = 0;
    int errors = 0;

    fp_mul_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_ovf    (out_ovf),
        .out_unf    (out_unf),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic        o;
        logic        u;
        int          lat;
    } vec_t;

    // Present operands for one cycle; returns just after the accept edge.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
    endtask

    // Count edges after the accept edge until out_valid is seen; -1 on timeout.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, want 1 0 0", in_ready, out_valid, busy);
        end
        checks++;
        if (out_result !== 16'h0000 || out_ovf !== 1'b0 || out_unf !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: result=%h ovf=%b unf=%b, want 0000 0 0", out_result, out_ovf, out_unf);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        vec_t vecs[9];
        int   lat;
        vecs[0] = '{16'h7C00, 16'h7C00, 16'h7400, 1'b0, 1'b0, 13};
        vecs[1] = '{16'h7FFF, 16'h7FFF, 16'h7FFE, 1'b0, 1'b0, 12};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 12};
        vecs[3] = '{16'h0400, 16'h0400, 16'h0000, 1'b0, 1'b1, 13};
        vecs[4] = '{16'h7800, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 12};
        vecs[5] = '{16'h7840, 16'h7C00, 16'h5400, 1'b0, 1'b0, 17};
        vecs[6] = '{16'hFC00, 16'h8400, 16'hFC00, 1'b0, 1'b0, 13};
        vecs[7] = '{16'h7C00, 16'h0C00, 16'h0400, 1'b0, 1'b0, 13};
        vecs[8] = '{16'h8400, 16'h7C00, 16'h7C00, 1'b0, 1'b0, 13};
        foreach (vecs[i]) begin
            start_op(vecs[i].a, vecs[i].b);
            checks++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL vec%0d_busy: in_ready=%b busy=%b, want 0 1", i, in_ready, busy);
            end
            wait_valid(lat);
            checks++;
            if (lat !== vecs[i].lat) begin
                errors++;
                $display("FAIL vec%0d_latency: got %0d, want %0d", i, lat, vecs[i].lat);
            end
            checks++;
            if (out_result !== vecs[i].r || out_ovf !== vecs[i].o || out_unf !== vecs[i].u) begin
                errors++;
                $display("FAIL vec%0d_result: %h*%h got %h ovf=%b unf=%b, want %h ovf=%b unf=%b",
                         i, vecs[i].a, vecs[i].b, out_result, out_ovf, out_unf, vecs[i].r, vecs[i].o, vecs[i].u);
            end
            handshake();
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL vec%0d_release: in_ready=%b out_valid=%b, want 1 0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        start_op(16'h7FFF, 16'h7FFF);
        wait_valid(lat);
        checks++;
        if (lat !== 12) begin
            errors++;
            $display("FAIL bp_latency: got %0d, want 12", lat);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 2) begin
                in_a     = 16'h7C00;
                in_b     = 16'h7C00;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== 16'h7FFE ||
                out_ovf !== 1'b0 || out_unf !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b in_ready=%b result=%h ovf=%b unf=%b, want 1 0 7ffe 0 0",
                         c, out_valid, in_ready, out_result, out_ovf, out_unf);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        handshake();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        // The operand pulsed during DONE must not have started an operation.
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_ignored: busy=%b out_valid=%b, want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_mid_reset();
        int lat;
        start_op(16'hFFFF, 16'hFFFF);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mreset_ctrl: in_ready=%b out_valid=%b busy=%b, want 1 0 0", in_ready, out_valid, busy);
        end
        checks++;
        if (out_result !== 16'h0000 || out_ovf !== 1'b0 || out_unf !== 1'b0) begin
            errors++;
            $display("FAIL mreset_out: result=%h ovf=%b unf=%b, want 0000 0 0", out_result, out_ovf, out_unf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        start_op(16'h7C00, 16'h7C00);
        wait_valid(lat);
        checks++;
        if (lat !== 13 || out_result !== 16'h7400 || out_ovf !== 1'b0 || out_unf !== 1'b0) begin
            errors++;
            $display("FAIL mreset_op: lat=%0d result=%h ovf=%b unf=%b, want 13 7400 0 0",
                     lat, out_result, out_ovf, out_unf);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        out_ready = 1'b1;
        start_op(16'h7840, 16'h7C00);
        wait_valid(lat);
        checks++;
        if (lat !== 17 || out_result !== 16'h5400) begin
            errors++;
            $display("FAIL b2b_first: lat=%0d result=%h, want 17 5400", lat, out_result);
        end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: in_ready=%b, want 1", in_ready);
        end
        start_op(16'h0400, 16'h0400);
        wait_valid(lat);
        checks++;
        if (lat !== 13 || out_result !== 16'h0000 || out_unf !== 1'b1 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: lat=%0d result=%h ovf=%b unf=%b, want 13 0000 0 1",
                     lat, out_result, out_ovf, out_unf);
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
